// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Step counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sub_serial_fulladd.sv
// Single-bit full-adder cell used by the serial datapath.
module fulladd (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic Q,
    output logic COUT
);

    assign Q    = A ^ B ^ CIN;
    assign COUT = (A & B) | (A & CIN) | (B & CIN);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: q = a - b, one bit per clock LSB first, via a + ~b + 1
// through one full-adder cell and a carry flop.
module sub_serial
    import sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned R_W   = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [R_W-1:0]   r_q,      r_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] q_q,      q_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic s;
    logic carry_next;

    fulladd u_fa (
        .A    (sa_q[0]),
        .B    (~sb_q[0]),
        .CIN  (carry_q),
        .Q    (s),
        .COUT (carry_next)
    );

    // Next-state and datapath; result regs only move on the final bit-step.
    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        q_d      = q_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d = carry_next;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                r_d     = R_W'({s, r_q} >> 1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    q_d      = {s, r_q};
                    borrow_d = ~carry_next;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            q_q      <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            q_q      <= q_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign q      = q_q;
    assign borrow = borrow_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
